// File: rtl/sram_biu_arbiter.sv
// Round-robin arbiter sharing one SRAM controller BIU port among several masters.
// A grant is held for a whole burst, and one idle bus cycle is inserted between grants.
module sram_biu_arbiter #(
  parameter int OPTN_NUM_REQ    = 2,
  parameter int OPTN_DATA_WIDTH = 16,
  parameter int OPTN_ADDR_WIDTH = 32,
  parameter int DATA_SIZE       = OPTN_DATA_WIDTH / 8
) (
  input  logic                                    clk,
  input  logic                                    n_rst,
  input  logic [OPTN_NUM_REQ-1:0]                 i_req_en,
  input  logic [OPTN_NUM_REQ-1:0]                 i_req_we,
  input  logic [OPTN_NUM_REQ-1:0]                 i_req_eob,
  input  logic [OPTN_NUM_REQ*DATA_SIZE-1:0]       i_req_sel,
  input  logic [OPTN_NUM_REQ*OPTN_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [OPTN_NUM_REQ*OPTN_DATA_WIDTH-1:0] i_req_data,
  output logic [OPTN_NUM_REQ-1:0]                 o_req_gnt,
  output logic [OPTN_NUM_REQ-1:0]                 o_req_done,
  output logic [OPTN_DATA_WIDTH-1:0]              o_req_data,
  output logic                                    o_biu_en,
  output logic                                    o_biu_we,
  output logic                                    o_biu_eob,
  output logic [DATA_SIZE-1:0]                    o_biu_sel,
  output logic [OPTN_ADDR_WIDTH-1:0]              o_biu_addr,
  output logic [OPTN_DATA_WIDTH-1:0]              o_biu_data,
  input  logic                                    i_biu_done,
  input  logic [OPTN_DATA_WIDTH-1:0]              i_biu_data
);

  localparam int N = OPTN_NUM_REQ;
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t       state_r, next_state_s;
  logic [N-1:0] gnt_r, next_gnt_s;
  logic [N-1:0] ptr_r, next_ptr_s;
  logic [N-1:0] mask_s, hi_req_s, cand_s, pick_s;
  logic         busy_s, last_beat_s;

  // Prefer requesters at or above the pointer; fall back to the lowest one otherwise (wrap).
  assign mask_s      = ~(ptr_r - ONE_HOT0);
  assign hi_req_s    = i_req_en & mask_s;
  assign cand_s      = (|hi_req_s) ? hi_req_s : i_req_en;
  assign pick_s      = cand_s & (~cand_s + ONE_HOT0);
  assign busy_s      = (state_r == BUSY);
  assign last_beat_s = busy_s & i_biu_done & (|(i_req_eob & gnt_r));

  // gnt_r is all-zero while idle, so the AND-OR mux below drives zeros with no extra gating.
  logic [DATA_SIZE-1:0]       sel_acc_s  [0:N];
  logic [OPTN_ADDR_WIDTH-1:0] addr_acc_s [0:N];
  logic [OPTN_DATA_WIDTH-1:0] data_acc_s [0:N];

  assign sel_acc_s[0]  = {DATA_SIZE{1'b0}};
  assign addr_acc_s[0] = {OPTN_ADDR_WIDTH{1'b0}};
  assign data_acc_s[0] = {OPTN_DATA_WIDTH{1'b0}};

  for (genvar r = 0; r < N; r++) begin : g_mux
    assign sel_acc_s[r+1]  = sel_acc_s[r] |
                             (i_req_sel[r*DATA_SIZE +: DATA_SIZE] & {DATA_SIZE{gnt_r[r]}});
    assign addr_acc_s[r+1] = addr_acc_s[r] |
                             (i_req_addr[r*OPTN_ADDR_WIDTH +: OPTN_ADDR_WIDTH] &
                              {OPTN_ADDR_WIDTH{gnt_r[r]}});
    assign data_acc_s[r+1] = data_acc_s[r] |
                             (i_req_data[r*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH] &
                              {OPTN_DATA_WIDTH{gnt_r[r]}});
  end

  assign o_req_gnt  = gnt_r;
  assign o_req_done = gnt_r & {N{i_biu_done}};
  assign o_req_data = busy_s ? i_biu_data : {OPTN_DATA_WIDTH{1'b0}};
  assign o_biu_en   = busy_s;
  assign o_biu_we   = busy_s & (|(i_req_we & gnt_r));
  assign o_biu_eob  = busy_s & (|(i_req_eob & gnt_r));
  assign o_biu_sel  = sel_acc_s[N];
  assign o_biu_addr = addr_acc_s[N];
  assign o_biu_data = data_acc_s[N];

  // Next-state, grant and pointer selection.
  always_comb begin
    next_state_s = state_r;
    next_gnt_s   = gnt_r;
    next_ptr_s   = ptr_r;
    case (state_r)
      IDLE: begin
        if (|i_req_en) begin
          next_state_s = BUSY;
          next_gnt_s   = pick_s;
        end else begin
          next_state_s = IDLE;
          next_gnt_s   = {N{1'b0}};
        end
      end
      BUSY: begin
        if (last_beat_s) begin
          next_state_s = IDLE;
          next_gnt_s   = {N{1'b0}};
          next_ptr_s   = {gnt_r[N-2:0], gnt_r[N-1]};
        end else begin
          next_state_s = BUSY;
          next_gnt_s   = gnt_r;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_gnt_s   = {N{1'b0}};
        next_ptr_s   = ONE_HOT0;
      end
    endcase
  end

  // State, grant and priority pointer registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
      gnt_r   <= {N{1'b0}};
      ptr_r   <= ONE_HOT0;
    end else begin
      state_r <= next_state_s;
      gnt_r   <= next_gnt_s;
      ptr_r   <= next_ptr_s;
    end
  end

endmodule

// File: tb/tb_sram_biu_arbiter.sv
// Randomized bench for sram_biu_arbiter: bus masters and an SRAM done/data source,
// checked every cycle against a round-robin reference model.
module tb_sram_biu_arbiter;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int DS = DW / 8;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [N-1:0]    i_req_en, i_req_we, i_req_eob;
  logic [N*DS-1:0] i_req_sel;
  logic [N*AW-1:0] i_req_addr;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]    o_req_gnt, o_req_done;
  logic [DW-1:0]   o_req_data;
  logic            o_biu_en, o_biu_we, o_biu_eob;
  logic [DS-1:0]   o_biu_sel;
  logic [AW-1:0]   o_biu_addr;
  logic [DW-1:0]   o_biu_data;
  logic            i_biu_done;
  logic [DW-1:0]   i_biu_data;

  always #5 clk = ~clk;

  sram_biu_arbiter #(
    .OPTN_NUM_REQ(N), .OPTN_DATA_WIDTH(DW), .OPTN_ADDR_WIDTH(AW), .DATA_SIZE(DS)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .i_req_en(i_req_en), .i_req_we(i_req_we), .i_req_eob(i_req_eob),
    .i_req_sel(i_req_sel), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_req_gnt(o_req_gnt), .o_req_done(o_req_done), .o_req_data(o_req_data),
    .o_biu_en(o_biu_en), .o_biu_we(o_biu_we), .o_biu_eob(o_biu_eob),
    .o_biu_sel(o_biu_sel), .o_biu_addr(o_biu_addr), .o_biu_data(o_biu_data),
    .i_biu_done(i_biu_done), .i_biu_data(i_biu_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side state: one outstanding burst per master.
  bit          act    [N];
  int          beats  [N];
  logic        we_q   [N];
  logic [AW-1:0] addr_q [N];
  logic [DS-1:0] sel_q  [N];
  logic [DW-1:0] data_q [N];

  // Reference model: idle/busy, granted index, round-robin pointer index.
  bit m_busy;
  int m_gnt;
  int m_ptr;

  task automatic start_burst(input int r, input int len, input logic we, input logic [AW-1:0] addr);
    act[r]    = 1'b1;
    beats[r]  = len;
    we_q[r]   = we;
    addr_q[r] = addr;
    sel_q[r]  = DS'($urandom_range(1, 3));
    data_q[r] = DW'($urandom);
  endtask

  task automatic drive_reqs();
    for (int r = 0; r < N; r++) begin
      if (act[r]) begin
        i_req_en[r]            = 1'b1;
        i_req_we[r]            = we_q[r];
        i_req_eob[r]           = (beats[r] == 1);
        i_req_sel[r*DS +: DS]  = sel_q[r];
        i_req_addr[r*AW +: AW] = addr_q[r];
        i_req_data[r*DW +: DW] = data_q[r];
      end else begin
        i_req_en[r]            = 1'b0;
        i_req_we[r]            = 1'($urandom_range(0, 1));
        i_req_eob[r]           = 1'($urandom_range(0, 1));
        i_req_sel[r*DS +: DS]  = DS'($urandom);
        i_req_addr[r*AW +: AW] = AW'($urandom);
        i_req_data[r*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  64'(o_req_gnt),  64'd0);
    check({tag, "_done"}, 64'(o_req_done), 64'd0);
    check({tag, "_rdat"}, 64'(o_req_data), 64'd0);
    check({tag, "_en"},   64'(o_biu_en),   64'd0);
    check({tag, "_we"},   64'(o_biu_we),   64'd0);
    check({tag, "_eob"},  64'(o_biu_eob),  64'd0);
    check({tag, "_sel"},  64'(o_biu_sel),  64'd0);
    check({tag, "_addr"}, 64'(o_biu_addr), 64'd0);
    check({tag, "_data"}, 64'(o_biu_data), 64'd0);
  endtask

  // One clock cycle: drive, check at the falling edge, advance model, step to after the rising edge.
  task automatic do_cycle(input int done_pct, input int new_pct);
    logic [63:0] exp_gnt;
    bit found;
    drive_reqs();
    i_biu_done = ($urandom_range(0, 99) < done_pct);
    i_biu_data = DW'($urandom);
    @(negedge clk);
    exp_gnt = m_busy ? (64'd1 << m_gnt) : 64'd0;
    check("gnt",  64'(o_req_gnt),  exp_gnt);
    check("done", 64'(o_req_done), i_biu_done ? exp_gnt : 64'd0);
    check("en",   64'(o_biu_en),   64'(m_busy));
    if (m_busy) begin
      check("we",   64'(o_biu_we),   64'(we_q[m_gnt]));
      check("eob",  64'(o_biu_eob),  64'(beats[m_gnt] == 1));
      check("sel",  64'(o_biu_sel),  64'(sel_q[m_gnt]));
      check("addr", 64'(o_biu_addr), 64'(addr_q[m_gnt]));
      check("wdat", 64'(o_biu_data), 64'(data_q[m_gnt]));
      if (i_biu_done) check("rdat", 64'(o_req_data), 64'(i_biu_data));
    end else begin
      check("idle_bus", 64'({o_biu_we, o_biu_eob, o_biu_sel, o_biu_addr, o_biu_data}), 64'd0);
    end
    if (m_busy) begin
      if (i_biu_done) begin
        if (beats[m_gnt] == 1) begin
          act[m_gnt] = 1'b0;
          m_busy     = 1'b0;
          m_ptr      = (m_gnt + 1) % N;
        end else begin
          beats[m_gnt]--;
          addr_q[m_gnt] = addr_q[m_gnt] + 32'd2;
          data_q[m_gnt] = DW'($urandom);
          sel_q[m_gnt]  = DS'($urandom_range(1, 3));
        end
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && act[(m_ptr + k) % N]) begin
          found  = 1'b1;
          m_gnt  = (m_ptr + k) % N;
          m_busy = 1'b1;
        end
      end
    end
    for (int r = 0; r < N; r++) begin
      if (!act[r] && ($urandom_range(0, 99) < new_pct))
        start_burst(r, $urandom_range(1, 4), 1'($urandom_range(0, 1)), AW'($urandom));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit reached;
    n_rst = 1'b0;
    for (int r = 0; r < N; r++) act[r] = 1'b0;
    m_busy = 1'b0; m_gnt = 0; m_ptr = 0;
    drive_reqs();
    i_req_en   = {N{1'b1}};
    i_biu_done = 1'b1;
    i_biu_data = 16'hBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    i_req_en   = {N{1'b0}};
    i_biu_done = 1'b0;
    n_rst      = 1'b1;
    @(posedge clk);
    #1;

    // Single read by requester 1 at 0x100, then spurious dones while idle.
    start_burst(1, 1, 1'b0, 32'h100);
    repeat (4) do_cycle(100, 0);
    repeat (3) do_cycle(100, 0);

    // Requester 0 burst of 4 with requester 1 and 2 waiting behind it.
    start_burst(0, 4, 1'b1, 32'h200);
    do_cycle(0, 0);
    start_burst(1, 1, 1'b0, 32'h300);
    start_burst(2, 2, 1'b0, 32'h400);
    repeat (14) do_cycle(70, 0);

    // Random contention and random SRAM done timing.
    repeat (1500) do_cycle(45, 35);
    repeat (40) do_cycle(60, 0);

    // Reset asserted during beat 2 of a 4-beat read.
    for (int r = 0; r < N; r++) act[r] = 1'b0;
    m_busy = 1'b0;
    repeat (4) do_cycle(0, 0);
    start_burst(0, 4, 1'b0, 32'h500);
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (m_busy && beats[0] == 3) reached = 1'b1;
      else do_cycle(100, 0);
    end
    check("rst_mid_burst_reached", 64'(reached), 64'd1);
    i_biu_done = 1'b1;
    n_rst      = 1'b0;
    #1;
    check_all_zero("rst_async");
    for (int r = 0; r < N; r++) act[r] = 1'b0;
    m_busy = 1'b0; m_ptr = 0;
    drive_reqs();
    @(negedge clk);
    i_biu_done = 1'b0;
    n_rst      = 1'b1;
    @(posedge clk);
    #1;
    start_burst(1, 1, 1'b0, 32'h100);
    start_burst(2, 1, 1'b0, 32'h600);
    repeat (8) do_cycle(100, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
